// File: rtl/enc42_sched_pkg.sv
// Shared constants and helpers for the enc42_sched request encoder.
// Included by the encoder top and its priority-search sub-module.
package enc_pkg;

   localparam int N_DEF = 4;

   function automatic int idx_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // Widest supported request vector is 16 lines; callers truncate to N.
   function automatic logic [15:0] onehot(input int unsigned idx, input int unsigned n);
      logic [15:0] v;
      v = '0;
      if (idx < n && idx < 16)
         v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/enc42_sched_prio_find.sv
// Combinational search over a request bitmap: highest index wins in fixed mode,
// or first set bit at/after (start+1) mod N with wrap-around in round-robin mode.
module prio_find
   import enc_pkg::*;
#(
   parameter  int N = N_DEF,
   localparam int W = idx_w(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] start,
   input  logic         rr_mode,
   output logic         found,
   output logic [W-1:0] idx
);

   always_comb begin
      found = |req;
      idx   = '0;
      if (rr_mode) begin
         // Walk farthest-first so the nearest candidate after start overwrites last.
         for (int k = N - 1; k >= 0; k--) begin
            if (req[W'(start + W'(k + 1))])
               idx = W'(start + W'(k + 1));
         end
      end else begin
         for (int k = 0; k < N; k++) begin
            if (req[k])
               idx = W'(k);
         end
      end
   end

endmodule

// File: rtl/enc42_sched.sv
// Registered N-to-log2(N) request encoder with sticky pending bitmap and valid/ready output.
// Define ENC42_SCHED_ROUND_ROBIN_EN to replace fixed highest-index priority with round-robin.
module enc42_sched
   import enc_pkg::*;
#(
   parameter  int N = N_DEF,
   localparam int W = idx_w(N)
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         EN,
   input  logic [N-1:0] IN,
   output logic [W-1:0] OUT,
   output logic         OUT_VALID,
   input  logic         OUT_READY,
   output logic         OVR,
   output logic         IDLE
);

   logic [N-1:0] r_pending;
   logic [W-1:0] r_out;
   logic         r_out_valid;
   logic         r_ovr;

   logic [N-1:0] w_set_vec;
   logic [N-1:0] w_clr_vec;
   logic [N-1:0] w_pending_next;
   logic         w_free;
   logic         w_found;
   logic [W-1:0] w_idx;
   logic [W-1:0] w_start;
   logic         w_rr_mode;

`ifdef ENC42_SCHED_ROUND_ROBIN_EN
   logic [W-1:0] r_ptr;

   // Reset to N-1 so the first search begins at index 0.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         r_ptr <= W'(N - 1);
      else if (w_free && w_found)
         r_ptr <= w_idx;
   end

   assign w_start   = r_ptr;
   assign w_rr_mode = 1'b1;
`else
   assign w_start   = '0;
   assign w_rr_mode = 1'b0;
`endif

   prio_find #(.N(N)) u_prio_find (
      .req     (r_pending),
      .start   (w_start),
      .rr_mode (w_rr_mode),
      .found   (w_found),
      .idx     (w_idx)
   );

   assign w_free    = !r_out_valid || OUT_READY;
   assign w_set_vec = EN ? IN : '0;
   assign w_clr_vec = (w_free && w_found) ? N'(onehot(32'(w_idx), N)) : '0;
   // A bit set and cleared in the same cycle stays pending (set wins).
   assign w_pending_next = (r_pending & ~w_clr_vec) | w_set_vec;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_pending   <= '0;
         r_out       <= '0;
         r_out_valid <= 1'b0;
         r_ovr       <= 1'b0;
      end else begin
         r_pending <= w_pending_next;
         r_ovr     <= |(w_set_vec & r_pending & ~w_clr_vec);
         if (w_free) begin
            r_out_valid <= w_found;
            if (w_found)
               r_out <= w_idx;
         end
      end
   end

   assign OUT       = r_out;
   assign OUT_VALID = r_out_valid;
   assign OVR       = r_ovr;
   assign IDLE      = (r_pending == '0) && !r_out_valid;

endmodule

// File: tb/tb_enc42_sched.sv
// Directed self-checking bench for enc42_sched; expectations adapt to the
// ENC42_SCHED_ROUND_ROBIN_EN build where selection order differs.
module tb_enc42_sched;

`ifdef ENC42_SCHED_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       EN = 1'b0;
   logic [3:0] IN = 4'b0000;
   logic [1:0] OUT;
   logic       OUT_VALID;
   logic       OUT_READY = 1'b0;
   logic       OVR;
   logic       IDLE;

   int n_cmp = 0;
   int n_err = 0;

   always #5 CLK = ~CLK;

   enc42_sched #(.N(4)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .EN        (EN),
      .IN        (IN),
      .OUT       (OUT),
      .OUT_VALID (OUT_VALID),
      .OUT_READY (OUT_READY),
      .OVR       (OVR),
      .IDLE      (IDLE)
   );

   task automatic check_val(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end else begin
         $display("ok   %s: %0d (t=%0t)", tag, got, $time);
      end
   endtask

   // Drive inputs, then advance past one rising edge to the following falling edge.
   task automatic cyc(input logic en, input logic [3:0] in, input logic rdy);
      EN        = en;
      IN        = in;
      OUT_READY = rdy;
      @(negedge CLK);
   endtask

   task automatic check_out(input string tag, input int idx);
      check_val({tag, "_valid"}, int'(OUT_VALID), 1);
      check_val({tag, "_out"}, int'(OUT), idx);
   endtask

   int rr_seq[6] = '{0, 1, 2, 3, 0, 1};

   initial begin
      @(negedge CLK);
      @(negedge CLK);
      check_val("rst_valid", int'(OUT_VALID), 0);
      check_val("rst_idle", int'(IDLE), 1);
      check_val("rst_ovr", int'(OVR), 0);
      check_val("rst_out", int'(OUT), 0);
      RST = 1'b0;

      // All-ones held: fixed serves only 3, round-robin rotates from 0.
      cyc(1'b1, 4'b1111, 1'b1);
      check_val("all1_first_valid", int'(OUT_VALID), 0);
      check_val("all1_first_ovr", int'(OVR), 0);
      for (int i = 0; i < 6; i++) begin
         cyc(1'b1, 4'b1111, 1'b1);
         check_out($sformatf("all1_%0d", i), RR ? rr_seq[i] : 3);
      end
      check_val("all1_ovr", int'(OVR), 1);

      // Asynchronous reset mid-run with requests still driven.
      #2 RST = 1'b1;
      #1;
      check_val("midrst_valid", int'(OUT_VALID), 0);
      check_val("midrst_idle", int'(IDLE), 1);
      check_val("midrst_ovr", int'(OVR), 0);
      @(negedge CLK);
      EN = 1'b0;
      IN = 4'b0000;
      @(negedge CLK);
      RST = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 4'b0000, 1'b1);
         check_val($sformatf("postrst_valid_%0d", i), int'(OUT_VALID), 0);
         check_val($sformatf("postrst_idle_%0d", i), int'(IDLE), 1);
      end

      // Burst 1011: fixed 3,1,0; round-robin from ptr=3 gives 0,1,3.
      cyc(1'b1, 4'b1011, 1'b1);
      check_val("burst_idle_busy", int'(IDLE), 0);
      check_val("burst_pre_valid", int'(OUT_VALID), 0);
      cyc(1'b0, 4'b0000, 1'b1);
      check_out("burst_a", RR ? 0 : 3);
      cyc(1'b0, 4'b0000, 1'b1);
      check_out("burst_b", 1);
      cyc(1'b0, 4'b0000, 1'b1);
      check_out("burst_c", RR ? 3 : 0);
      cyc(1'b0, 4'b0000, 1'b1);
      check_val("burst_end_valid", int'(OUT_VALID), 0);
      check_val("burst_end_idle", int'(IDLE), 1);

      // Backpressure 0110: first index must hold through the stall.
      cyc(1'b1, 4'b0110, 1'b0);
      for (int i = 0; i < 5; i++) begin
         cyc(1'b0, 4'b0000, 1'b0);
         check_out($sformatf("bp_hold_%0d", i), RR ? 1 : 2);
         check_val($sformatf("bp_ovr_%0d", i), int'(OVR), 0);
      end
      cyc(1'b0, 4'b0000, 1'b1);
      check_out("bp_second", RR ? 2 : 1);
      cyc(1'b0, 4'b0000, 1'b1);
      check_val("bp_end_valid", int'(OUT_VALID), 0);
      check_val("bp_end_idle", int'(IDLE), 1);

      // Merge: occupy the slot with index 2, then request bit 0 twice.
      cyc(1'b1, 4'b0100, 1'b0);
      cyc(1'b0, 4'b0000, 1'b0);
      check_out("mrg_slot", 2);
      cyc(1'b1, 4'b0001, 1'b0);
      check_val("mrg_ovr_first", int'(OVR), 0);
      cyc(1'b1, 4'b0001, 1'b0);
      check_val("mrg_ovr_merge", int'(OVR), 1);
      cyc(1'b0, 4'b0000, 1'b0);
      check_val("mrg_ovr_drop", int'(OVR), 0);
      check_out("mrg_still", 2);
      cyc(1'b0, 4'b0000, 1'b1);
      check_out("mrg_deliver", 0);
      cyc(1'b0, 4'b0000, 1'b1);
      check_val("mrg_single_valid", int'(OUT_VALID), 0);
      check_val("mrg_single_idle", int'(IDLE), 1);

      // EN gating: requests without enable are ignored.
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, 4'b1111, 1'b1);
         check_val($sformatf("engate_valid_%0d", i), int'(OUT_VALID), 0);
         check_val($sformatf("engate_idle_%0d", i), int'(IDLE), 1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/enc42_sched.md
Name: enc42_sched

Overview:
- Registered 4-to-2 request encoder; the reverse direction of the team's 2-to-4 decoder (DEC24).
- Captures request lines into a sticky pending bitmap.
- Emits one binary index per accepted transfer over a valid/ready output, clearing each serviced request.
- Sits upstream of DEC24, which re-expands OUT into a one-hot select.

Parameters:
- N, 4, number of request lines (power of two, 2..16)
- W, $clog2(N), index width (derived, not overridden)

Ports:
- CLK  input  1  rising-edge clock
- RST  input  1  asynchronous active-high reset
- EN  input  1  capture enable; IN is ignored when 0
- IN  input  N  request lines, any number set per cycle
- OUT  output  W  encoded index of the serviced request
- OUT_VALID  output  1  OUT holds a valid index
- OUT_READY  input  1  downstream accepts OUT this cycle
- OVR  output  1  one-cycle pulse: a request merged into an already-pending bit
- IDLE  output  1  no pending requests and OUT_VALID=0

Behaviour:
- Reset (async, RST=1): pending=0, OUT=0, OUT_VALID=0, OVR=0, IDLE=1, rr pointer=N-1. Any in-flight or pending request is dropped.
- Capture: set_vec = EN ? IN : 0. pending_next = (pending & ~clr_vec) | set_vec.
  - If a bit is set and cleared in the same cycle, the set wins and the request is re-pended.
- Slot free when OUT_VALID=0 or OUT_READY=1.
- On a free slot with pending≠0:
  - OUT <= selected index; OUT_VALID <= 1; clr_vec = one-hot of that index.
- On a free slot with pending=0: OUT_VALID <= 0; OUT holds its last value.
- Stall: while OUT_VALID=1 and OUT_READY=0, OUT and OUT_VALID hold, and pending only accumulates.
- Selection (default): fixed priority, highest index wins (IN[3] over IN[2] ... over IN[0]).
- Latency: IN/EN sampled at edge t → pending at t → OUT_VALID at edge t+1 when the slot is free. There is no combinational path from IN to OUT.
- Throughput: one index per cycle while OUT_READY=1.
- OVR <= 1 for one cycle when any bit of (set_vec & pending & ~clr_vec) is set; otherwise 0. This is registered.
- IDLE is combinational: (pending==0) && !OUT_VALID.
- All-ones input with EN held: every bit is re-pended each cycle, so with fixed priority only index N-1 is served. This starvation is expected in fixed mode.

Optional Feature:
- Macro: ENC42_SCHED_ROUND_ROBIN_EN.
- Defined:
  - Selection searches pending ascending from (ptr+1) mod N, with wrap-around.
  - ptr <= selected index on each load.
  - The ptr reset value of N-1 makes the first search start at index 0.
- Undefined:
  - Fixed highest-index priority.
  - ptr register absent and not synthesised.
- Port list is identical in both builds.

Decomposition:
- Package enc_pkg holds:
  - localparam N_DEF=4
  - function idx_w(n), the clog2 wrapper
  - function onehot(idx, n)
- Sub-module prio_find (combinational):
  - Inputs: req[N-1:0], start[W-1:0], rr_mode.
  - Outputs: found, idx[W-1:0].
  - Fixed mode ignores start.
- enc42_sched is the only sequential module.

Test Plan:
- Reset: drive IN=4'b1111, EN=1, then assert RST mid-run → OUT_VALID=0, IDLE=1, OVR=0 immediately; no output after RST deasserts until new requests arrive.
- Burst: one cycle of EN=1, IN=4'b1011, OUT_READY=1 → OUT=3,1,0 on three consecutive cycles with OUT_VALID=1, then OUT_VALID=0 and IDLE=1.
- Backpressure: IN=4'b0110 once, OUT_READY=0 for 5 cycles → OUT=2 held stable with OUT_VALID=1; after READY=1, OUT=2 is accepted, then OUT=1.
- Merge/OVR: IN=4'b0001 (EN=1) with OUT_READY=0 → OVR=0 on load; IN=4'b0001 again while bit 0 is pending → OVR=1 for exactly one cycle; a single OUT=0 is later delivered.
- EN gating: IN=4'b1111 with EN=0 for 4 cycles → no OUT_VALID, IDLE stays 1.
- ENC42_SCHED_ROUND_ROBIN_EN build: IN=4'b1111 held with EN=1, READY=1 → OUT sequence 0,1,2,3,0,1 ... In the fixed build the same stimulus gives OUT=3 every cycle.
